// File: rtl/store_narrow.sv
// Store narrowing unit: byte/half/word stores into word-only memory via RMW.
// Optional macro STORE_NARROW_BE_EN: byte-enable writes, no read phase.
module store_narrow (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic        half_q, half_d;
    logic [15:0] data_q, data_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [29:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        bad;
    logic [31:0] merged;

    // Alignment/size legality of the incoming request
    always_comb begin
        bad = (size == 2'b11)
            | ((size == 2'b01) & addr[0])
            | ((size == 2'b10) & (|addr[1:0]));
    end

    // Replace the addressed lane(s) of the read word with the store data
    always_comb begin
        merged = mem_rdata;
        if (half_q) begin
            if (lane_q[1]) merged[31:16] = data_q;
            else           merged[15:0]  = data_q;
        end else begin
            case (lane_q)
                2'd0: merged[7:0]   = data_q[7:0];
                2'd1: merged[15:8]  = data_q[7:0];
                2'd2: merged[23:16] = data_q[7:0];
                2'd3: merged[31:24] = data_q[7:0];
            endcase
        end
    end

    // Next-state and next-output logic; every output comes from a flop
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        half_d      = half_q;
        data_d      = data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lane_d     = addr[1:0];
                    half_d     = (size == 2'b01);
                    data_d     = wdata[15:0];
                    mem_addr_d = addr[31:2];
                    busy_d     = 1'b1;
                    if (bad) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (size == 2'b10) begin
                        state_d     = S_WR;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = wdata;
                        mem_be_d    = 4'hF;
                    end else begin
`ifdef STORE_NARROW_BE_EN
                        state_d   = S_WR;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b1;
                        if (size == 2'b00) begin
                            mem_wdata_d = {4{wdata[7:0]}};
                            mem_be_d    = 4'b0001 << addr[1:0];
                        end else begin
                            mem_wdata_d = {2{wdata[15:0]}};
                            mem_be_d    = addr[1] ? 4'b1100 : 4'b0011;
                        end
`else
                        state_d   = S_RD;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        mem_be_d  = 4'h0;
`endif
                    end
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    state_d     = S_WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged;
                    mem_be_d    = 4'hF;
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'h0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, captured request and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lane_q      <= 2'd0;
            half_q      <= 1'b0;
            data_q      <= 16'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 30'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            half_q      <= half_d;
            data_q      <= data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_narrow.sv
// Testbench for store_narrow: memory responder, reference model, scoreboard.
// Works with or without STORE_NARROW_BE_EN defined.
module tb_store_narrow;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        err;

    store_narrow dut (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size),
        .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
        .done(done), .err(err)
    );

    typedef struct {
        bit        err;
        int        lat;
        bit [29:0] waddr;
        bit [31:0] wword;
        bit [3:0]  be;
        int        nrd;
        int        nwr;
        int        scyc;
    } exp_t;

    exp_t        exp_q[$];
    int          dly_q[$];
    logic [31:0] mem [logic [29:0]];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_total = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return {2'b00, a} * 32'h9E37_79B1 ^ 32'h5A3C_0F11;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Memory responder: acks each request after a queued number of wait cycles
    initial begin
        int  wcnt;
        bit  active;
        logic [31:0] w;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        active = 0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mem_ack = 1'b0;
                active = 0;
            end else begin
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (!active) begin
                        active = 1;
                        wcnt = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
                    end
                    if (wcnt == 0) begin
                        active = 0;
                        mem_ack = 1'b1;
                        if (mem_we) begin
                            w = mem_rd(mem_addr);
                            for (int i = 0; i < 4; i++)
                                if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                            mem[mem_addr] = w;
                            wr_total++;
                            mem_rdata = $urandom;
                        end else begin
                            mem_rdata = mem_rd(mem_addr);
                        end
                    end else begin
                        wcnt--;
                    end
                end
            end
        end
    end

    // Monitor: checks every completed memory access and every done pulse
    initial begin
        int   rd_seen;
        int   wr_seen;
        logic p_req, p_ack, p_we;
        logic [29:0] p_addr;
        logic [31:0] p_wdata;
        exp_t e;
        rd_seen = 0;
        wr_seen = 0;
        p_req = 0;
        p_ack = 0;
        p_we = 0;
        p_addr = '0;
        p_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_seen = 0;
                wr_seen = 0;
                p_req = 0;
            end else begin
                if (p_req && !p_ack && mem_req)
                    check("req_hold",
                          {31'd0, (mem_we == p_we && mem_addr == p_addr
                                   && mem_wdata == p_wdata)}, 32'd1);
                if (mem_req && mem_ack) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                    end else if (mem_we) begin
                        wr_seen++;
                        check("wr_addr", {2'b0, mem_addr}, {2'b0, exp_q[0].waddr});
                        check("wr_data", mem_wdata, exp_q[0].wword);
                        check("wr_be", {28'd0, mem_be}, {28'd0, exp_q[0].be});
                    end else begin
                        rd_seen++;
                        check("rd_addr", {2'b0, mem_addr}, {2'b0, exp_q[0].waddr});
                    end
                end
                if (err && !done) check("err_without_done", 32'd1, 32'd0);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("err", {31'd0, err}, {31'd0, e.err});
                        check("latency", cyc - e.scyc, e.lat);
                        check("num_reads", rd_seen, e.nrd);
                        check("num_writes", wr_seen, e.nwr);
                    end
                    rd_seen = 0;
                    wr_seen = 0;
                end
                p_req = mem_req;
                p_ack = mem_ack;
                p_we = mem_we;
                p_addr = mem_addr;
                p_wdata = mem_wdata;
            end
        end
    end

    // Reference model: expected outcome of a store from the request alone
    task automatic issue(input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int d0, input int d1);
        exp_t e;
        logic [31:0] old;
        logic [31:0] msk;
        int sh;
        @(negedge clk);
        e.waddr = a[31:2];
        e.err = (sz == 2'b11) || (sz == 2'b01 && a[0])
             || (sz == 2'b10 && a[1:0] != 2'b00);
        e.nrd = 0;
        e.nwr = 0;
        e.wword = '0;
        e.be = '0;
        if (e.err) begin
            e.lat = 1;
        end else if (sz == 2'b10) begin
            e.lat = 2 + d0;
            e.nwr = 1;
            e.wword = wd;
            e.be = 4'hF;
            dly_q.push_back(d0);
        end else begin
            e.nwr = 1;
            sh = (sz == 2'b00) ? 8 * a[1:0] : 16 * a[1];
            msk = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
`ifdef STORE_NARROW_BE_EN
            e.lat = 2 + d0;
            e.wword = (sz == 2'b00) ? {4{wd[7:0]}} : {2{wd[15:0]}};
            e.be = (sz == 2'b00) ? (4'h1 << (sh / 8)) : (4'h3 << (sh / 8));
            dly_q.push_back(d0);
`else
            e.lat = 3 + d0 + d1;
            e.nrd = 1;
            old = mem_rd(a[31:2]);
            e.wword = (old & ~(msk << sh)) | ((wd & msk) << sh);
            e.be = 4'hF;
            dly_q.push_back(d0);
            dly_q.push_back(d1);
`endif
        end
        e.scyc = cyc;
        exp_q.push_back(e);
        size = sz;
        addr = a;
        wdata = wd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for completion, throwing ignored start pulses at the busy DUT
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy) begin
            if (n > 200) begin
                check("idle_timeout", 32'd1, 32'd0);
                start = 1'b0;
                return;
            end
            start = ($urandom_range(0, 2) == 0);
            size = 2'($urandom);
            addr = $urandom;
            wdata = $urandom;
            n++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int n;
        logic [1:0]  rs;
        logic [31:0] ra;
        int wr_before;
        rst_n = 1'b0;
        start = 1'b0;
        size = 2'b00;
        addr = '0;
        wdata = '0;
        #3;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {2'b0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        mem[30'h40] = 32'h1122_3344;
        issue(2'b00, 32'h101, 32'h0000_00AB, 0, 0);
        wait_idle();
        check("sb_mem", mem_rd(30'h40), 32'h1122_AB44);

        mem[30'h40] = 32'h1122_3344;
        issue(2'b01, 32'h102, 32'h0000_BEEF, 0, 0);
        wait_idle();
        check("sh_mem", mem_rd(30'h40), 32'hBEEF_3344);

        issue(2'b10, 32'h101, 32'h1234_5678, 0, 0);
        wait_idle();
        issue(2'b01, 32'h003, 32'h1234_5678, 0, 0);
        wait_idle();
        issue(2'b11, 32'h100, 32'h1234_5678, 0, 0);
        wait_idle();

        issue(2'b10, 32'h200, 32'hCAFE_F00D, 3, 0);
        wait_idle();
        check("sw_mem", mem_rd(30'h80), 32'hCAFE_F00D);

        issue(2'b00, 32'h103, 32'h0000_005A, 1, 2);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            rs = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ra = 32'h300 + $urandom_range(0, 31);
            issue(rs, ra, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            wait_idle();
        end
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        mem[30'h60] = 32'hA5A5_A5A5;
        wr_before = wr_total;
        issue(2'b00, 32'h182, 32'h0000_0077, 8, 8);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_test_req_seen", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_be", {28'd0, mem_be}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        dly_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_req", {31'd0, mem_req}, 32'd0);
        check("post_rst_no_write", wr_total - wr_before, 32'd0);
        check("post_rst_mem", mem_rd(30'h60), 32'hA5A5_A5A5);

        issue(2'b01, 32'h182, 32'h0000_1357, 0, 0);
        wait_idle();
        check("after_rst_mem", mem_rd(30'h60), 32'h1357_A5A5);
        repeat (2) @(negedge clk);
        check("final_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
